// File: rtl/fifo_uart_drain_if.sv
// ============================================================================
// fifo_uart_drain_if : pop-side handshake between a byte FIFO and its drain
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fifo_uart_drain_if;
  logic       rd;
  logic [7:0] dout;
  logic       nostock;

  // master is the drain that issues pops; slave is the FIFO itself
  modport master (output rd, input dout, input nostock);
  modport slave  (input rd, output dout, output nostock);
endinterface

`default_nettype wire

// File: rtl/fifo_uart_drain.sv
// ============================================================================
// fifo_uart_drain : pops bytes from a FIFO and sends them as 8N1 / 8E1 UART
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_uart_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  fifo_uart_drain_if.master        fifo_if,
  input  logic                     en_i,
  output logic                     txd_o,
  output logic                     busy_o,
  output logic                     tx_done_o,
  output logic [7:0]               frame_cnt_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] C_BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic          rd_q, rd_d;
  logic          txd_q, txd_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          w_bit_end;
  logic          w_in_bit;

  assign w_bit_end = (baud_q == C_BAUD_LAST);
  assign w_in_bit  = (state_q == S_START) || (state_q == S_DATA) ||
                     (state_q == S_PARITY) || (state_q == S_STOP);

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    txd_d   = txd_q;
    shift_d = shift_q;
    par_d   = par_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    baud_d  = '0;
    if (w_in_bit && !w_bit_end) begin
      baud_d = baud_q + BW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (en_i && !fifo_if.nostock) begin
          state_d = S_FETCH;
          rd_d    = 1'b1;
        end
      end
      S_FETCH: begin
        rd_d    = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = fifo_if.dout;
        par_d   = ^fifo_if.dout;
        txd_d   = 1'b0;
        idx_d   = 3'd0;
        state_d = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            // next bit is pre-shifted so txd always comes from shift_q[1]
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      txd_q   <= 1'b1;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      baud_q  <= '0;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      txd_q   <= txd_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_if.rd  = rd_q;
  assign txd_o       = txd_q;
  assign busy_o      = (state_q != S_IDLE);
  assign tx_done_o   = (state_q == S_STOP) && w_bit_end;
  assign frame_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: doc/fifo_uart_drain.md
# fifo_uart_drain

Downstream consumer of the 8-bit byte FIFO. It pops one byte at a time through the FIFO's `rd`/`dout`/`nostock` interface and serialises each byte onto a UART transmit line: 8N1, or 8E1 when parity is enabled. It never over-reads the FIFO: at most one `rd` pulse is issued per frame, and only while `nostock` is low.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal minimum is 2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between the data bits and the stop bit.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  drain enable, sampled only in IDLE.
- `nostock`  in  1  FIFO empty flag.
- `dout`  in  8  FIFO read data. Valid one cycle after the cycle in which `rd` was high.
- `rd`  out  1  FIFO pop request, registered, exactly one cycle wide.
- `txd`  out  1  serial output, registered; idles high.
- `busy`  out  1  high whenever the state is not IDLE.
- `tx_done`  out  1  one-cycle pulse in the last cycle of the stop bit.
- `frame_cnt`  out  8  count of completed frames; wraps 255 -> 0.

## Operation
- The state machine has seven states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: if `en`=1 and `nostock`=0 at the clock edge, go to FETCH with `rd`<=1. Otherwise stay in IDLE.
- FETCH: `rd` is high for this single cycle; the FIFO pops on the edge that ends it. Next state is LOAD, with `rd`<=0.
- LOAD: capture `dout` into the 8-bit shift register, compute the parity bit as XOR of the byte, set `txd`<=0, clear the bit counter, and go to START.
- START: hold `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: send 8 bits LSB first, each for `CLKS_PER_BIT` cycles. A 3-bit index counts 0..7.
- After bit 7, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
- PARITY: `txd` = XOR of the 8 data bits (even parity), held for `CLKS_PER_BIT` cycles.
- STOP: `txd`=1 for `CLKS_PER_BIT` cycles. In the last cycle `tx_done`=1, and on that edge `frame_cnt` increments and the state returns to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, is reset at every bit boundary, and a bit ends when the count equals CLKS_PER_BIT-1.
- `en` and `nostock` are ignored outside IDLE. Dropping `en` mid-frame lets the current frame complete; no further `rd` follows.
- Consequence: the FIFO never sees `rd` while empty, provided `nostock` is correct in IDLE.
- Reset (asynchronous) values:
  - State IDLE.
  - `rd`=0, `txd`=1, `busy`=0, `tx_done`=0, `frame_cnt`=0.
  - Shift register and counters cleared.
  - A frame in progress is abandoned and its byte is lost. The line returns high immediately; no partial stop bit is driven.

## Timing
- Let cycle N be an IDLE cycle with `en`=1 and `nostock`=0. Then:
  - N+1: `rd`=1 (FETCH).
  - N+2: LOAD.
  - N+3: first cycle of `txd`=0.
- Frame length on `txd`, from start-bit falling edge to the end of the stop bit:
  - (10 + `PARITY_EN`) × `CLKS_PER_BIT` cycles.
  - `tx_done` is high in cycle N+3 + (10+`PARITY_EN`)×`CLKS_PER_BIT` − 1.
- Back-to-back with `nostock`=0:
  - After the stop bit there are exactly 3 extra high cycles on `txd` (IDLE, FETCH, LOAD) before the next start bit.
  - `rd` pulses are spaced (10+`PARITY_EN`)×`CLKS_PER_BIT`+3 cycles apart.
- `busy` rises in cycle N+1 and falls in the cycle after `tx_done`.
- `frame_cnt` updates on the edge ending the `tx_done` cycle.

## Test plan
- Reset: hold `rst`=1 mid-frame.
  - Required: `txd`=1, `rd`=0, `busy`=0 and `tx_done`=0 without waiting for a clock edge, and `frame_cnt`=0.
  - After release with `nostock`=0 and `en`=1: a fresh `rd` pulse 1 cycle after the first IDLE evaluation.
- `CLKS_PER_BIT`=4, `PARITY_EN`=0, FIFO holds 0xA5, `nostock` falls at cycle N. Required:
  - `rd` high only in N+1.
  - `txd` = 0, then 1,0,1,0,0,1,0,1, then 1, each value held 4 cycles, starting at N+3.
  - `tx_done` at N+42; `frame_cnt`=1.
- `PARITY_EN`=1, byte 0x07. Required:
  - Parity bit = 1 (0x07 has three ones, so even parity needs a 1); a byte with an even number of ones, e.g. 0x03, gives parity bit 0.
  - Frame is 44 cycles; `tx_done` at N+46.
- Five bytes 0x11..0x15 preloaded, `nostock` goes high after the 5th pop. Required:
  - Exactly 5 `rd` pulses, spaced 43 cycles apart.
  - Data appears in order on `txd`; no 6th `rd`; `frame_cnt`=5.
- `en`=0 with `nostock`=0 for 100 cycles: no `rd`, `txd` stays 1.
  - Then set `en`=1 and drop it after 2 cycles. Required: one frame completes fully, then no further `rd`.
- `frame_cnt` wrap: run 256 frames. Required: `frame_cnt` reads 255 and then 0.
